// File: rtl/multi_phase_signal_controller_if.sv
// Demand inputs and lamp outputs of the N-phase signal controller.
interface multi_phase_signal_controller_if #(
    parameter int N_PHASES = 4
);
    localparam int PW = (N_PHASES > 1) ? $clog2(N_PHASES) : 1;

    logic [N_PHASES-1:0] req;
    logic                ped_req;
    logic [N_PHASES-1:0] green;
    logic [N_PHASES-1:0] yellow;
    logic [N_PHASES-1:0] red;
    logic                walk;
    logic [PW-1:0]       active_phase;
    logic                ped_pending;

    modport master (
        output req, ped_req,
        input  green, yellow, red, walk, active_phase, ped_pending
    );

    modport slave (
        input  req, ped_req,
        output green, yellow, red, walk, active_phase, ped_pending
    );
endinterface

// File: rtl/multi_phase_signal_controller.sv
// N-phase signal controller: round-robin green with gap-out/max-out, yellow,
// all-red clearance and an exclusive pedestrian walk interval.
module multi_phase_signal_controller #(
    parameter int N_PHASES    = 4,
    parameter int CNT_W       = 8,
    parameter int T_MIN_GREEN = 14,
    parameter int T_MAX_GREEN = 40,
    parameter int T_YELLOW    = 4,
    parameter int T_ALL_RED   = 2,
    parameter int T_WALK      = 10,
    parameter int HOME_PHASE  = 0
) (
    input  logic Clk,
    input  logic reset,
    multi_phase_signal_controller_if.slave bus
);
    localparam int PW = (N_PHASES > 1) ? $clog2(N_PHASES) : 1;
    localparam logic [PW-1:0]    HOME     = PW'(HOME_PHASE);
    localparam logic [CNT_W-1:0] T_MIN_M1 = CNT_W'(T_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] T_MAX_M1 = CNT_W'(T_MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] T_Y_M1   = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] T_AR_M1  = CNT_W'(T_ALL_RED - 1);
    localparam logic [CNT_W-1:0] T_W_M1   = CNT_W'(T_WALK - 1);
    localparam logic [CNT_W-1:0] T_SAT    = '1;

    typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALL_RED, S_WALK} state_t;

    state_t           state, state_n;
    logic [PW-1:0]    p, p_n, q, q_n;
    logic [CNT_W-1:0] timer, timer_n;
    logic             ped_pend, ped_n;
    logic             walk_done, walk_done_n;

    logic [PW-1:0]       nxt, cand;
    logic                found;
    logic [N_PHASES-1:0] others;
    logic                other;

    // Round-robin search from p+1 with wrap; falls back to home, then to p.
    always_comb begin
        nxt   = (p != HOME) ? HOME : p;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k < N_PHASES; k++) begin
            cand = PW'((int'(p) + k) % N_PHASES);
            if (!found && bus.req[cand]) begin
                nxt   = cand;
                found = 1'b1;
            end
        end
    end

    assign others = bus.req & ~({{(N_PHASES-1){1'b0}}, 1'b1} << p);
    assign other  = (|others) || (p != HOME);

    always_comb begin
        state_n     = state;
        p_n         = p;
        q_n         = q;
        walk_done_n = walk_done;
        ped_n       = ped_pend | (bus.ped_req & (state != S_WALK));
        unique case (state)
            S_GREEN:
                if (timer >= T_MIN_M1 && (other || ped_pend) &&
                    (!bus.req[p] || timer == T_MAX_M1)) begin
                    state_n = S_YELLOW;
                    q_n     = nxt;
                end
            S_YELLOW:
                if (timer == T_Y_M1) state_n = S_ALL_RED;
            S_ALL_RED:
                if (timer == T_AR_M1) begin
                    if (ped_pend && !walk_done) begin
                        state_n = S_WALK;
                        ped_n   = 1'b0;
                    end else begin
                        state_n     = S_GREEN;
                        p_n         = q;
                        walk_done_n = 1'b0;
                    end
                end
            S_WALK:
                if (timer == T_W_M1) begin
                    state_n     = S_ALL_RED;
                    walk_done_n = 1'b1;
                end
        endcase
        if (state_n != state)  timer_n = '0;
        else if (timer == T_SAT) timer_n = timer;
        else                   timer_n = timer + 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state     <= S_GREEN;
            p         <= HOME;
            q         <= HOME;
            timer     <= '0;
            ped_pend  <= 1'b0;
            walk_done <= 1'b0;
        end else begin
            state     <= state_n;
            p         <= p_n;
            q         <= q_n;
            timer     <= timer_n;
            ped_pend  <= ped_n;
            walk_done <= walk_done_n;
        end
    end

    always_comb begin
        bus.green  = '0;
        bus.yellow = '0;
        if (state == S_GREEN)  bus.green[p]  = 1'b1;
        if (state == S_YELLOW) bus.yellow[p] = 1'b1;
        bus.red = ~(bus.green | bus.yellow);
    end

    assign bus.walk         = (state == S_WALK);
    assign bus.active_phase = p;
    assign bus.ped_pending  = ped_pend;
endmodule

// File: tb/tb_multi_phase_signal_controller.sv
// Bench for the N-phase signal controller: dwell-count reference model checked
// every cycle, plus literal timeline checks.
module tb_multi_phase_signal_controller;
    localparam int N    = 4;
    localparam int TMIN = 14;
    localparam int TMAX = 40;
    localparam int TY   = 4;
    localparam int TAR  = 2;
    localparam int TW   = 10;
    localparam int HOME = 0;

    logic Clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    multi_phase_signal_controller_if #(.N_PHASES(N)) ifc ();

    multi_phase_signal_controller #(
        .N_PHASES(N), .CNT_W(8), .T_MIN_GREEN(TMIN), .T_MAX_GREEN(TMAX),
        .T_YELLOW(TY), .T_ALL_RED(TAR), .T_WALK(TW), .HOME_PHASE(HOME)
    ) dut (
        .Clk(Clk),
        .reset(reset),
        .bus(ifc)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference: mode 0 green, 1 yellow, 2 all-red, 3 walk; dwell never saturates.
    int m_mode, m_p, m_q, m_dwell;
    bit m_ped, m_walked, m_valid = 1'b0;

    function automatic int pick(logic [N-1:0] r, int p);
        for (int k = 1; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return (p != HOME) ? HOME : p;
    endfunction

    always @(posedge Clk) begin
        logic [N-1:0] r;
        bit pr, want, to_walk;
        int nm;
        r  = ifc.req;
        pr = ifc.ped_req;
        if (reset) begin
            m_mode = 0; m_p = HOME; m_q = HOME; m_dwell = 0;
            m_ped = 1'b0; m_walked = 1'b0; m_valid = 1'b1;
        end else if (m_valid) begin
            nm = m_mode;
            to_walk = 1'b0;
            case (m_mode)
                0: begin
                    want = ((r & ~(4'b0001 << m_p)) != 0) || (m_p != HOME) || m_ped;
                    if (m_dwell >= TMIN - 1 && want && (!r[m_p] || m_dwell == TMAX - 1)) begin
                        nm = 1;
                        m_q = pick(r, m_p);
                    end
                end
                1: if (m_dwell == TY - 1) nm = 2;
                2: if (m_dwell == TAR - 1) begin
                       if (m_ped && !m_walked) begin nm = 3; to_walk = 1'b1; end
                       else begin nm = 0; m_p = m_q; m_walked = 1'b0; end
                   end
                default: if (m_dwell == TW - 1) begin nm = 2; m_walked = 1'b1; end
            endcase
            if (pr && m_mode != 3) m_ped = 1'b1;
            if (to_walk) m_ped = 1'b0;
            m_dwell = (nm != m_mode) ? 0 : m_dwell + 1;
            m_mode  = nm;
        end
    end

    always @(negedge Clk) begin
        logic [N-1:0] eg, ey;
        if (m_valid) begin
            eg = (m_mode == 0) ? N'(1 << m_p) : '0;
            ey = (m_mode == 1) ? N'(1 << m_p) : '0;
            checks++;
            if (ifc.green !== eg || ifc.yellow !== ey || ifc.red !== ~(eg | ey) ||
                ifc.walk !== (m_mode == 3) || ifc.active_phase !== 2'(m_p) ||
                ifc.ped_pending !== m_ped) begin
                errors++;
                $display("FAIL model t=%0t: got g=%b y=%b r=%b w=%b ph=%0d pp=%b, want g=%b y=%b r=%b w=%b ph=%0d pp=%b",
                         $time, ifc.green, ifc.yellow, ifc.red, ifc.walk, ifc.active_phase,
                         ifc.ped_pending, eg, ey, ~(eg | ey), (m_mode == 3), m_p, m_ped);
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge Clk);
        cyc++;
    endtask

    task automatic run_to(int c);
        while (cyc < c) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ifc.req = '0;
        ifc.ped_req = 1'b0;
        @(negedge Clk);
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic all_red(string name);
        chk({name, "_g"}, 32'(ifc.green), 0);
        chk({name, "_y"}, 32'(ifc.yellow), 0);
        chk({name, "_r"}, 32'(ifc.red), 32'hf);
    endtask

    initial begin
        reset = 1'b1;
        ifc.req = '0;
        ifc.ped_req = 1'b0;

        // Idle rest in home green
        do_reset();
        chk("rst_green", 32'(ifc.green), 32'h1);
        chk("rst_phase", 32'(ifc.active_phase), 0);
        chk("rst_walk", 32'(ifc.walk), 0);
        run_to(200);
        chk("idle_green", 32'(ifc.green), 32'h1);
        chk("idle_red", 32'(ifc.red), 32'he);
        chk("idle_walk", 32'(ifc.walk), 0);

        // Gap-out of home to phase 2, then return home
        do_reset();
        ifc.req = 4'b0100;
        run_to(13); chk("s2_g13", 32'(ifc.green), 32'h1);
        run_to(14); chk("s2_y14", 32'(ifc.yellow), 32'h1);
        run_to(18); all_red("s2_ar18");
        run_to(20); chk("s2_g20", 32'(ifc.green), 32'h4);
        run_to(50); ifc.req = '0;
        run_to(51); chk("s2_y51", 32'(ifc.yellow), 32'h4);
        run_to(56); all_red("s2_ar56");
        run_to(57); chk("s2_g57", 32'(ifc.green), 32'h1);

        // Max-out, then round robin skips 0 in favour of 3
        do_reset();
        ifc.req = 4'b0011;
        run_to(39); chk("mx_g39", 32'(ifc.green), 32'h1);
        run_to(40); chk("mx_y40", 32'(ifc.yellow), 32'h1);
        run_to(44); all_red("mx_ar44");
        run_to(46); chk("mx_g46", 32'(ifc.green), 32'h2);
        ifc.req = 4'b1001;
        run_to(59); chk("rr_g59", 32'(ifc.green), 32'h2);
        run_to(60); chk("rr_y60", 32'(ifc.yellow), 32'h2);
        run_to(66); chk("rr_g66", 32'(ifc.green), 32'h8);
        chk("rr_ph", 32'(ifc.active_phase), 3);

        // Pedestrian walk from idle home green
        do_reset();
        run_to(3); ifc.ped_req = 1'b1;
        run_to(4); ifc.ped_req = 1'b0;
        chk("pd_pend", 32'(ifc.ped_pending), 1);
        run_to(14); chk("pd_y14", 32'(ifc.yellow), 32'h1);
        run_to(20); chk("pd_w20", 32'(ifc.walk), 1); all_red("pd_w20");
        chk("pd_clr", 32'(ifc.ped_pending), 0);
        run_to(29); chk("pd_w29", 32'(ifc.walk), 1);
        run_to(30); chk("pd_w30", 32'(ifc.walk), 0); all_red("pd_ar30");
        run_to(32); chk("pd_g32", 32'(ifc.green), 32'h1);

        // Reset during yellow1 with a pending walk
        do_reset();
        ifc.req = 4'b0010;
        run_to(20); chk("ry_g20", 32'(ifc.green), 32'h2);
        run_to(21); ifc.req = '0; ifc.ped_req = 1'b1;
        run_to(22); ifc.ped_req = 1'b0;
        run_to(34); chk("ry_y34", 32'(ifc.yellow), 32'h2);
        chk("ry_pend", 32'(ifc.ped_pending), 1);
        run_to(35); reset = 1'b1;
        tick();
        reset = 1'b0;
        ifc.req = 4'b0010;
        chk("ry_g0", 32'(ifc.green), 32'h1);
        chk("ry_y0", 32'(ifc.yellow), 0);
        chk("ry_pclr", 32'(ifc.ped_pending), 0);
        run_to(49); chk("ry_g49", 32'(ifc.green), 32'h1);
        run_to(50); chk("ry_y50", 32'(ifc.yellow), 32'h1);

        // Randomized demand, pedestrian pulses and occasional resets
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 15) == 0) ifc.req = 4'($urandom_range(0, 15));
            ifc.ped_req = ($urandom_range(0, 24) == 0);
            reset = ($urandom_range(0, 999) == 0);
            tick();
        end
        reset = 1'b0;
        ifc.ped_req = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
